sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single external 256K×16 asynchronous SRAM on the audio board. The record path (ADC samples → SRAM) and the playback path (SRAM → DAC samples) each issue request/acknowledge transactions, and this block alternates between them fairly. It generates the SRAM strobe timing (CE/OE/WE/UB/LB) and drives or releases the bidirectional data bus. It sits between the codec datapath and the SRAM pins at the top level, and its address output also feeds the time display.

---
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: fair two-port arbiter and strobe sequencer for a 256Kx16
// asynchronous SRAM. Record (write) and playback (read) paths share the part;
// ties alternate, and every pin-facing output comes straight from a flop so
// the SRAM sees glitch-free strobes.
module sram_arbiter #(
  parameter int unsigned ACC_CYCLES = 2   // OE/WE low time in CLK50 cycles, 1..15
) (
  input  logic        CLK50,
  input  logic        RESET_KEY,
  input  logic        wr_req,
  input  logic [17:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DATA,
  output logic        SRAM_CE,
  output logic        SRAM_OE,
  output logic        SRAM_WE,
  output logic        SRAM_UB,
  output logic        SRAM_LB
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_SETUP  = 3'd1;
  localparam logic [2:0] S_WR_PULSE  = 3'd2;
  localparam logic [2:0] S_WR_HOLD   = 3'd3;
  localparam logic [2:0] S_RD_ACCESS = 3'd4;
  localparam logic [2:0] S_RD_DONE   = 3'd5;

  // Counter counts down to zero, so a strobe phase lasts CNT_LOAD+1 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_wr_q, last_wr_d;     // 1: write was granted last
  logic        grant_wr, grant_rd;

  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic [15:0] dout_q, dout_d;
  logic [17:0] addr_q, addr_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        busy_q, busy_d;

  // Grant decision and state sequencing; grants are only made from IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A tie goes to whichever side did not win last time.
        grant_wr = wr_req && (!rd_req || !last_wr_q);
        grant_rd = rd_req && !grant_wr;
        if (grant_wr) begin
          state_d   = S_WR_SETUP;
          last_wr_d = 1'b1;
        end else if (grant_rd) begin
          state_d   = S_RD_ACCESS;
          cnt_d     = CNT_LOAD;
          last_wr_d = 1'b0;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HOLD:  state_d = S_IDLE;
      S_RD_ACCESS: begin
        if (cnt_q == 4'd0) state_d = S_RD_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RD_DONE:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output next-values are decoded from the next state so the registered
  // pins line up with the state they belong to, with no extra cycle of lag.
  always_comb begin
    ce_n_d    = (state_d == S_IDLE);
    oe_n_d    = (state_d != S_RD_ACCESS);
    we_n_d    = (state_d != S_WR_PULSE);
    drive_d   = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                (state_d == S_WR_HOLD);
    wr_ack_d  = (state_d == S_WR_HOLD);
    rd_ack_d  = (state_d == S_RD_DONE);
    busy_d    = (state_d != S_IDLE);
    addr_d    = addr_q;
    dout_d    = dout_q;
    rd_data_d = rd_data_q;
    if (grant_wr) begin
      addr_d = wr_addr;
      dout_d = wr_data;
    end else if (grant_rd) begin
      addr_d = rd_addr;
    end
    // Sample the bus on the edge that closes the final OE-low cycle.
    if ((state_q == S_RD_ACCESS) && (cnt_q == 4'd0)) rd_data_d = SRAM_DATA;
  end

  // State, counter and arbitration history.
  always_ff @(posedge CLK50 or negedge RESET_KEY) begin
    if (!RESET_KEY) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Registered pin/handshake outputs; async reset drops strobes and frees
  // the bus the moment RESET_KEY falls, aborting any access in flight.
  always_ff @(posedge CLK50 or negedge RESET_KEY) begin
    if (!RESET_KEY) begin
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
      dout_q    <= 16'h0000;
      addr_q    <= 18'h00000;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= 16'h0000;
      busy_q    <= 1'b0;
    end else begin
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign SRAM_DATA = drive_q ? dout_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE   = ce_n_q;
  assign SRAM_UB   = ce_n_q;   // always full 16-bit accesses
  assign SRAM_LB   = ce_n_q;
  assign SRAM_OE   = oe_n_q;
  assign SRAM_WE   = we_n_q;
  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed steps from reset through abort, an
// ACC_CYCLES=1 instance for short-strobe timing, then randomized traffic
// scored against a transaction-level memory/arbitration model.
module tb_sram_arbiter;

  localparam int ACC  = 2;
  localparam int WLAT = ACC + 2;   // wr_ack cycle after the request cycle
  localparam int RLAT = ACC + 1;   // rd_ack cycle after the request cycle

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req, wr_req_b, rd_req_b;
  logic [17:0] wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic        wr_ack_a, rd_ack_a, busy_a, ce_a, oe_a, we_a, ub_a, lb_a;
  logic [15:0] rd_data_a;
  logic [17:0] sram_addr_a;
  wire  [15:0] sram_data_a;

  logic        wr_ack_b, rd_ack_b, busy_b, ce_b, oe_b, we_b, ub_b, lb_b;
  logic [15:0] rd_data_b;
  logic [17:0] sram_addr_b;
  wire  [15:0] sram_data_b;

  always #10 clk = ~clk;

  sram_arbiter #(.ACC_CYCLES(ACC)) u_dut (
    .CLK50(clk), .RESET_KEY(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_a),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack_a), .rd_data(rd_data_a),
    .busy(busy_a), .SRAM_ADDR(sram_addr_a), .SRAM_DATA(sram_data_a),
    .SRAM_CE(ce_a), .SRAM_OE(oe_a), .SRAM_WE(we_a), .SRAM_UB(ub_a), .SRAM_LB(lb_a)
  );

  sram_arbiter #(.ACC_CYCLES(1)) u_dut1 (
    .CLK50(clk), .RESET_KEY(rst_n),
    .wr_req(wr_req_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
    .busy(busy_b), .SRAM_ADDR(sram_addr_b), .SRAM_DATA(sram_data_b),
    .SRAM_CE(ce_b), .SRAM_OE(oe_b), .SRAM_WE(we_b), .SRAM_UB(ub_b), .SRAM_LB(lb_b)
  );

  // Released bus reads as all ones.
  pullup (sram_data_a);
  pullup (sram_data_b);

  // Behavioural SRAM for the main instance; a fixed-pattern part for the other.
  logic [15:0] mem [0:262143];
  assign sram_data_a = (!ce_a && !oe_a) ? mem[sram_addr_a] : 16'hzzzz;
  assign sram_data_b = (!ce_b && !oe_b) ? 16'hBEEF : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_a && !we_a) mem[sram_addr_a] <= sram_data_a;
  end

  // Strobe legality: OE and WE never low together; neither without CE.
  int viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((!oe_a && !we_a) || (!oe_b && !we_b)) viol <= viol + 1;
      if (((!oe_a || !we_a) && ce_a) || ((!oe_b || !we_b) && ce_b)) viol <= viol + 1;
    end
  end

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: memory contents and who won last.
  logic [15:0] ref_mem [int];
  bit          last_w;

  // kind: 0 write only, 1 read only, 2 both at once.
  task automatic do_op(input int kind, input logic [17:0] wa, input logic [15:0] wd,
                       input logic [17:0] ra);
    bit want_w, want_r, w_first;
    int exp_w, exp_r, got_w, got_r, cyc;
    logic [15:0] exp_d, got_d;
    want_w  = (kind != 1);
    want_r  = (kind != 0);
    w_first = (want_w && want_r) ? !last_w : want_w;
    exp_w = 0; exp_r = 0;
    if (want_w && want_r) begin
      if (w_first) begin exp_w = WLAT; exp_r = WLAT + 1 + RLAT; end
      else         begin exp_r = RLAT; exp_w = RLAT + 1 + WLAT; end
    end else begin
      exp_w = WLAT; exp_r = RLAT;
    end
    exp_d = ref_mem.exists(int'(ra)) ? ref_mem[int'(ra)] : 16'h0000;
    if (want_w && want_r && w_first && (ra == wa)) exp_d = wd;
    if (want_w) ref_mem[int'(wa)] = wd;
    if (want_w && want_r) last_w = !w_first;
    else                  last_w = want_w;

    wr_addr = wa; wr_data = wd; rd_addr = ra;
    wr_req = want_w; rd_req = want_r;
    got_w = -1; got_r = -1; got_d = 16'h0000; cyc = 0;
    while ((wr_req || rd_req) && cyc < 40) begin
      step();
      cyc++;
      if (wr_ack_a) begin got_w = cyc; wr_req = 1'b0; end
      if (rd_ack_a) begin got_r = cyc; got_d = rd_data_a; rd_req = 1'b0; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    if (want_w) chk("op_wack_cycle", got_w, exp_w);
    if (want_r) begin
      chk("op_rack_cycle", got_r, exp_r);
      chk("op_rd_data", got_d, exp_d);
    end
    step();
    chk("op_idle_busy", busy_a, 1'b0);
  endtask

  initial begin
    int n, cyc, we_lo;
    int seq [4];
    int at [4];
    logic [15:0] dat [4];
    logic [17:0] pool [8];
    int exp_at [4];
    exp_at = '{4, 8, 13, 17};

    rst_n = 1'b0;
    wr_req = 0; rd_req = 0; wr_req_b = 0; rd_req_b = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    last_w = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_we", we_a, 1'b1);
    chk("rst_oe", oe_a, 1'b1);
    chk("rst_ce_ub_lb", {ce_a, ub_a, lb_a}, 3'b111);
    chk("rst_addr", sram_addr_a, 18'h0);
    chk("rst_bus_released", sram_data_a, 16'hFFFF);
    chk("rst_acks", {wr_ack_a, rd_ack_a}, 2'b00);
    chk("rst_rd_data", rd_data_a, 16'h0);
    chk("rst_busy", busy_a, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", busy_a, 1'b0);
    chk("idle_ce", ce_a, 1'b1);

    // Single write, per-cycle strobe timing
    wr_addr = 18'h00ABC; wr_data = 16'h1234; wr_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("w_addr_c%0d", c), sram_addr_a, 18'h00ABC);
      chk($sformatf("w_bus_c%0d", c), sram_data_a, 16'h1234);
      chk($sformatf("w_we_c%0d", c), we_a, (c == 2 || c == 3) ? 1'b0 : 1'b1);
      chk($sformatf("w_ack_c%0d", c), wr_ack_a, (c == 4) ? 1'b1 : 1'b0);
      chk($sformatf("w_ce_c%0d", c), ce_a, 1'b0);
      if (c == 4) wr_req = 1'b0;
    end
    step();
    chk("w_after_bus", sram_data_a, 16'hFFFF);
    chk("w_after_busy", busy_a, 1'b0);
    chk("w_after_addr_hold", sram_addr_a, 18'h00ABC);
    ref_mem[32'hABC] = 16'h1234;
    last_w = 1'b1;

    // Read back
    rd_addr = 18'h00ABC; rd_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("r_oe_c%0d", c), oe_a, (c <= 2) ? 1'b0 : 1'b1);
      chk($sformatf("r_we_c%0d", c), we_a, 1'b1);
      chk($sformatf("r_ack_c%0d", c), rd_ack_a, (c == 3) ? 1'b1 : 1'b0);
      if (c == 3) begin
        chk("r_data", rd_data_a, 16'h1234);
        rd_req = 1'b0;
      end
    end
    repeat (10) step();
    chk("r_data_held", rd_data_a, 16'h1234);
    last_w = 1'b0;

    // Fairness after a fresh reset: W, R, W, R with both held
    rst_n = 1'b0; step(); @(negedge clk); rst_n = 1'b1; step();
    wr_addr = 18'h00155; wr_data = 16'h5A5A; rd_addr = 18'h00ABC;
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin seq[k] = 2; at[k] = -1; dat[k] = 16'h0; end
    while (n < 4 && cyc < 60) begin
      step();
      cyc++;
      if (wr_ack_a && n < 4) begin seq[n] = 1; at[n] = cyc; n++; end
      if (rd_ack_a && n < 4) begin seq[n] = 0; at[n] = cyc; dat[n] = rd_data_a; n++; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fair_side_%0d", k), seq[k], (k % 2 == 0) ? 1 : 0);
      chk($sformatf("fair_cycle_%0d", k), at[k], exp_at[k]);
    end
    chk("fair_rd1", dat[1], 16'h1234);
    chk("fair_rd3", dat[3], 16'h1234);
    ref_mem[32'h155] = 16'h5A5A;
    step();
    last_w = 1'b0;

    // Abort in the second WE-low cycle
    wr_addr = 18'h002AA; wr_data = 16'hC3C3; wr_req = 1'b1;
    repeat (3) step();
    chk("abort_pre_we", we_a, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_we", we_a, 1'b1);
    chk("abort_bus", sram_data_a, 16'hFFFF);
    chk("abort_ce", ce_a, 1'b1);
    chk("abort_busy", busy_a, 1'b0);
    wr_req = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin step(); if (wr_ack_a) n++; end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin step(); if (wr_ack_a) n++; end
    chk("abort_no_ack", n, 0);
    ref_mem.delete(32'h2AA);
    last_w = 1'b0;
    do_op(0, 18'h002AA, 16'h0F0F, 18'h0);
    do_op(1, 18'h0, 16'h0, 18'h002AA);

    // ACC_CYCLES=1 instance
    rd_req_b = 1'b1; cyc = 0; n = -1;
    while (rd_req_b && cyc < 20) begin
      step(); cyc++;
      if (rd_ack_b) begin n = cyc; rd_req_b = 1'b0; chk("acc1_rd_data", rd_data_b, 16'hBEEF); end
    end
    rd_req_b = 1'b0;
    chk("acc1_rd_ack_cycle", n, 2);
    step();
    wr_req_b = 1'b1; cyc = 0; n = -1; we_lo = 0;
    while (wr_req_b && cyc < 20) begin
      step(); cyc++;
      if (!we_b) we_lo++;
      if (wr_ack_b) begin n = cyc; wr_req_b = 1'b0; end
    end
    wr_req_b = 1'b0;
    chk("acc1_wr_ack_cycle", n, 3);
    chk("acc1_we_low_cycles", we_lo, 1);
    step();

    // Randomized traffic against the reference model
    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'($urandom);
      do_op(0, pool[i], 16'($urandom), 18'h0);
    end
    for (int i = 0; i < 30; i++) begin
      do_op(int'($urandom_range(0, 2)), pool[$urandom_range(0, 7)], 16'($urandom),
            pool[$urandom_range(0, 7)]);
      repeat ($urandom_range(0, 3)) step();
    end

    chk("strobe_overlap_count", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
